// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction-memory request
// at a time, buffers the response for decode and squashes wrong-path responses.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  input  logic                  if_ready,
  input  logic                  redirect_en,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DRAIN
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [DATA_WIDTH-1:0] req_pc_reg, req_pc_next;
  logic [DATA_WIDTH-1:0] if_pc_reg, if_pc_next;
  logic [DATA_WIDTH-1:0] if_instr_reg, if_instr_next;
  logic                  if_valid_reg, if_valid_next;
  logic                  misaligned_reg, misaligned_next;
  logic [DATA_WIDTH-1:0] redirect_pc;

  assign redirect_pc = {redirect_target[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      req_pc_reg     <= '0;
      if_pc_reg      <= '0;
      if_instr_reg   <= '0;
      if_valid_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      req_pc_reg     <= req_pc_next;
      if_pc_reg      <= if_pc_next;
      if_instr_reg   <= if_instr_next;
      if_valid_reg   <= if_valid_next;
      misaligned_reg <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    req_pc_next     = req_pc_reg;
    if_pc_next      = if_pc_reg;
    if_instr_next   = if_instr_reg;
    if_valid_next   = if_valid_reg;
    misaligned_next = redirect_en && (redirect_target[1:0] != 2'b00);

    case (state_reg)
      S_IDLE: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + DATA_WIDTH'(4);
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !redirect_en) begin
          if_instr_next = imem_rdata;
          if_pc_next    = req_pc_reg;
          if_valid_next = 1'b1;
          state_next    = S_VALID;
        end
      end
      S_VALID: begin
        if (if_ready) begin
          if_valid_next = 1'b0;
          state_next    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase

    // Redirect overrides everything; the only question is whether a squashed
    // request is still outstanding and must be drained first.
    if (redirect_en) begin
      fetch_pc_next = redirect_pc;
      if_valid_next = 1'b0;
      case (state_reg)
        S_REQ:   state_next = imem_gnt ? S_DRAIN : S_REQ;
        S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DRAIN;
        // A response consumed in the same cycle ends the drain, else we would hang.
        S_DRAIN: state_next = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_next = S_REQ;
      endcase
    end
  end

  assign imem_req   = (state_reg == S_REQ);
  assign imem_addr  = fetch_pc_reg;
  assign if_valid   = if_valid_reg;
  assign if_pc      = if_pc_reg;
  assign if_instr   = if_instr_reg;
  assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; the bench plays instruction
// memory and decode, with hand-computed expected values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        misaligned;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int t_req0, t_req1;

  fetch_sequencer #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .redirect_en    (redirect_en),
    .redirect_target(redirect_target),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Starts in REQ; ends one cycle after rvalid with the instruction presented.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    chk("req_hi", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req_lo", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    chk("if_valid", {31'd0, if_valid}, 32'd1);
    chk("if_pc", if_pc, addr);
    chk("if_instr", if_instr, data);
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_misal", {31'd0, misaligned}, 32'd0);
    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();

    // Sequential fetch, one instruction per 3 cycles
    if_ready = 1'b1;
    t_req0 = cyc;
    fetch_one(32'h0000_0100, 32'h1111_1111);
    step();
    t_req1 = cyc;
    chk("accept_drop", {31'd0, if_valid}, 32'd0);
    chk("throughput", t_req1 - t_req0, 32'd3);
    fetch_one(32'h0000_0104, 32'h2222_2222);
    step();
    if_ready = 1'b0;
    fetch_one(32'h0000_0108, 32'h3333_3333);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h0000_0108);
      chk("stall_instr", if_instr, 32'h3333_3333);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    if_ready = 1'b1;
    step();
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h0000_010C);
    chk("unstall_valid", {31'd0, if_valid}, 32'd0);

    // Redirect in REQ without gnt, then redirect while WAIT -> DRAIN
    redirect_en = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_en = 1'b0;
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0200);
    chk("redir_misal", {31'd0, misaligned}, 32'd0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_en = 1'b1;
    redirect_target = 32'h0000_0400;
    step();
    redirect_en = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_instr", if_instr, 32'h3333_3333);
    fetch_one(32'h0000_0400, 32'h4444_4444);

    // Redirect in VALID with same-cycle if_ready
    redirect_en = 1'b1;
    redirect_target = 32'h0000_0080;
    step();
    redirect_en = 1'b0;
    chk("vredir_valid", {31'd0, if_valid}, 32'd0);
    chk("vredir_req", {31'd0, imem_req}, 32'd1);
    chk("vredir_addr", imem_addr, 32'h0000_0080);

    // Misaligned target and PC wrap
    redirect_en = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    step();
    redirect_en = 1'b0;
    chk("misal_pulse", {31'd0, misaligned}, 32'd1);
    chk("misal_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("misal_end", {31'd0, misaligned}, 32'd0);
    fetch_one(32'hFFFF_FFFC, 32'h5555_5555);
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset mid-WAIT, then stale rvalid in IDLE and REQ
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0000_0100);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h6666_6666;
    step();
    step();
    imem_rvalid = 1'b0;
    chk("stale_valid", {31'd0, if_valid}, 32'd0);
    chk("stale_instr", if_instr, 32'd0);
    fetch_one(32'h0000_0100, 32'h7777_7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
